// File: rtl/icache_pkg.sv
// Shared types and helpers for the N-way instruction-cache controller.
package icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_A,
        ST_MISS_D,
        ST_REFILL,
        ST_CACOP
    } state_e;

    localparam logic [1:0] CACOP_IDX_INV0 = 2'd0;
    localparam logic [1:0] CACOP_IDX_INV1 = 2'd1;
    localparam logic [1:0] CACOP_HIT_INV  = 2'd2;
    localparam logic [1:0] CACOP_NOP      = 2'd3;

    // Callers truncate the result to their own way count.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/icache_ctrl_nway_if.sv
// Fetch-side and memory read-channel signals of the instruction-cache controller.
interface icache_ctrl_nway_if #(
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic              rvalid;
    logic [31:0]       addr;
    logic              uncache;
    logic [WAYS-1:0]   hit;
    logic [WAY_W-1:0]  victim_way;
    logic              cacop_en;
    logic [1:0]        cacop_code;
    logic              i_arready;
    logic              i_rvalid;
    logic              i_rlast;

    logic              rready;
    logic              i_arvalid;
    logic [31:0]       i_araddr;
    logic [7:0]        i_arlen;
    logic              i_rready;
    logic              beat_we;
    logic [IDX_W-1:0]  beat_idx;
    logic [WAYS-1:0]   mem_we;
    logic [WAYS-1:0]   tagv_we;
    logic              tagv_inval;
    logic              rbuf_we;
    logic              data_from_mem_sel;
    logic              lru_update;
    logic              lru_fill;
    logic [WAY_W-1:0]  fill_way;
    logic              cacop_finish;
    logic              busy;

    modport master (
        output rvalid, addr, uncache, hit, victim_way, cacop_en, cacop_code,
               i_arready, i_rvalid, i_rlast,
        input  rready, i_arvalid, i_araddr, i_arlen, i_rready, beat_we, beat_idx,
               mem_we, tagv_we, tagv_inval, rbuf_we, data_from_mem_sel,
               lru_update, lru_fill, fill_way, cacop_finish, busy
    );

    modport slave (
        input  rvalid, addr, uncache, hit, victim_way, cacop_en, cacop_code,
               i_arready, i_rvalid, i_rlast,
        output rready, i_arvalid, i_araddr, i_arlen, i_rready, beat_we, beat_idx,
               mem_we, tagv_we, tagv_inval, rbuf_we, data_from_mem_sel,
               lru_update, lru_fill, fill_way, cacop_finish, busy
    );

endinterface

// File: rtl/icache_beat_cnt.sv
// Refill beat counter: cleared when a burst starts, advances per accepted beat, wraps per line.
module icache_beat_cnt #(
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          clr,
    input  logic                          inc,
    output logic [$clog2(LINE_WORDS)-1:0] cnt
);
    localparam int CNT_W = $clog2(LINE_WORDS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == CNT_W'(LINE_WORDS - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/icache_ctrl_nway.sv
// N-way instruction-cache control FSM: lookup, line refill / uncached read, CACOP invalidation.
module icache_ctrl_nway
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input logic               clk,
    input logic               rstn,
    icache_ctrl_nway_if.slave bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = OFF_W - 2;

    state_e            state;
    state_e            state_nxt;
    logic [WAY_W-1:0]  fill_way_q;
    logic              uncached_q;
    logic [31:0]       miss_addr_q;
    logic [IDX_W-1:0]  beat_cnt;
    logic              any_hit;
    logic              miss_start;
    logic              cnt_clr;
    logic              cnt_inc;
    logic [WAYS-1:0]   fill_oh;
    logic [WAYS-1:0]   idx_oh;

    assign any_hit    = |bus.hit;
    assign miss_start = (state == ST_LOOKUP) && !bus.cacop_en && (bus.uncache || !any_hit);
    assign cnt_clr    = (state == ST_MISS_A) && bus.i_arready;
    assign cnt_inc    = (state == ST_MISS_D) && bus.i_rvalid;
    assign fill_oh    = WAYS'(onehot8(3'(fill_way_q)));
    assign idx_oh     = WAYS'(onehot8(3'(bus.addr[WAY_W-1:0])));

    icache_beat_cnt #(.LINE_WORDS(LINE_WORDS)) u_beat_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (beat_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            fill_way_q <= '0;
            uncached_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (miss_start) begin
                uncached_q <= bus.uncache;
                if (!bus.uncache) fill_way_q <= bus.victim_way;
            end
        end
    end

    // Burst address is frozen at miss time so it cannot move while i_arvalid is pending.
    always_ff @(posedge clk) begin
        if (miss_start) begin
            miss_addr_q <= bus.uncache ? {bus.addr[31:2], 2'b00}
                                       : {bus.addr[31:OFF_W], {OFF_W{1'b0}}};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.cacop_en)    state_nxt = ST_CACOP;
                else if (bus.rvalid) state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (bus.cacop_en)     state_nxt = ST_CACOP;
                else if (bus.uncache) state_nxt = ST_MISS_A;
                else if (any_hit)     state_nxt = bus.rvalid ? ST_LOOKUP : ST_IDLE;
                else                  state_nxt = ST_MISS_A;
            end
            ST_MISS_A: if (bus.i_arready) state_nxt = ST_MISS_D;
            ST_MISS_D: begin
                if (bus.i_rvalid && bus.i_rlast) state_nxt = uncached_q ? ST_IDLE : ST_REFILL;
            end
            ST_REFILL: state_nxt = ST_IDLE;
            ST_CACOP:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.rready            = 1'b0;
        bus.i_arvalid         = 1'b0;
        bus.i_araddr          = '0;
        bus.i_arlen           = '0;
        bus.i_rready          = 1'b0;
        bus.beat_we           = 1'b0;
        bus.beat_idx          = '0;
        bus.mem_we            = '0;
        bus.tagv_we           = '0;
        bus.tagv_inval        = 1'b0;
        bus.rbuf_we           = 1'b0;
        bus.data_from_mem_sel = 1'b0;
        bus.lru_update        = 1'b0;
        bus.lru_fill          = 1'b0;
        bus.fill_way          = fill_way_q;
        bus.cacop_finish      = 1'b0;
        bus.busy              = (state != ST_IDLE) && (state != ST_LOOKUP);
        case (state)
            ST_IDLE: begin
                bus.rready            = 1'b1;
                bus.rbuf_we           = 1'b1;
                bus.data_from_mem_sel = 1'b1;
            end
            ST_LOOKUP: begin
                if (!bus.cacop_en && !bus.uncache && any_hit) begin
                    bus.rready     = 1'b1;
                    bus.rbuf_we    = 1'b1;
                    bus.lru_update = 1'b1;
                end
            end
            ST_MISS_A: begin
                bus.i_arvalid = 1'b1;
                bus.i_araddr  = miss_addr_q;
                bus.i_arlen   = uncached_q ? 8'd0 : 8'(LINE_WORDS - 1);
            end
            ST_MISS_D: begin
                bus.i_rready = 1'b1;
                bus.beat_we  = bus.i_rvalid;
                bus.beat_idx = beat_cnt;
                if (bus.i_rvalid && bus.i_rlast && uncached_q) begin
                    bus.rready            = 1'b1;
                    bus.data_from_mem_sel = 1'b1;
                end
            end
            ST_REFILL: begin
                bus.mem_we            = fill_oh;
                bus.tagv_we           = fill_oh;
                bus.lru_fill          = 1'b1;
                bus.rready            = 1'b1;
                bus.data_from_mem_sel = 1'b1;
            end
            ST_CACOP: begin
                bus.tagv_inval   = 1'b1;
                bus.cacop_finish = 1'b1;
                case (bus.cacop_code)
                    CACOP_IDX_INV0, CACOP_IDX_INV1: bus.tagv_we = idx_oh;
                    CACOP_HIT_INV:                  bus.tagv_we = bus.hit;
                    default:                        bus.tagv_we = '0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Cycle-vector bench for icache_ctrl_nway (4 ways, 4-word lines) with a refill-beat scoreboard.
module tb_icache_ctrl_nway;

    typedef struct {
        string       name;
        logic        rvalid;
        logic [31:0] addr;
        logic        unc;
        logic [3:0]  hit;
        logic [1:0]  vic;
        logic        cop;
        logic [1:0]  code;
        logic        arr;
        logic        rvd;
        logic        rl;
        logic [10:0] ctl;
        logic [3:0]  mw;
        logic [3:0]  tw;
        logic [31:0] ara;
        logic [7:0]  arl;
    } vec_t;

    // ctl bits: rready rbuf_we dfms | lru_update lru_fill | arvalid i_rready beat_we | inval finish | busy
    localparam logic [10:0] O_IDLE   = 11'b111_00_000_00_0;
    localparam logic [10:0] O_HIT    = 11'b110_10_000_00_0;
    localparam logic [10:0] O_NONE   = 11'b000_00_000_00_0;
    localparam logic [10:0] O_ARV    = 11'b000_00_100_00_1;
    localparam logic [10:0] O_BEAT   = 11'b000_00_011_00_1;
    localparam logic [10:0] O_WAIT   = 11'b000_00_010_00_1;
    localparam logic [10:0] O_LAST_U = 11'b101_00_011_00_1;
    localparam logic [10:0] O_REFILL = 11'b101_01_000_00_1;
    localparam logic [10:0] O_COP    = 11'b000_00_000_11_1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   exp_beat = 0;
    int   sb_q[$];
    vec_t vecs[$];
    logic [10:0] ctl_now;

    always #5 clk = ~clk;

    icache_ctrl_nway_if #(.WAYS(4), .LINE_WORDS(4)) bus ();

    icache_ctrl_nway #(.WAYS(4), .LINE_WORDS(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    assign ctl_now = {bus.rready, bus.rbuf_we, bus.data_from_mem_sel, bus.lru_update, bus.lru_fill,
                      bus.i_arvalid, bus.i_rready, bus.beat_we, bus.tagv_inval, bus.cacop_finish, bus.busy};

    function automatic vec_t v(input string nm, input logic rv, input logic [31:0] a, input logic unc,
                               input logic [3:0] h, input logic [1:0] vic, input logic cop,
                               input logic [1:0] cd, input logic arr, input logic rvd, input logic rl,
                               input logic [10:0] ctl, input logic [3:0] mw, input logic [3:0] tw,
                               input logic [31:0] ara, input logic [7:0] arl);
        vec_t t;
        t.name = nm; t.rvalid = rv; t.addr = a; t.unc = unc; t.hit = h; t.vic = vic;
        t.cop = cop; t.code = cd; t.arr = arr; t.rvd = rvd; t.rl = rl; t.ctl = ctl;
        t.mw = mw; t.tw = tw; t.ara = ara; t.arl = arl;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.rvalid = 1'b0; bus.addr = '0; bus.uncache = 1'b0; bus.hit = '0; bus.victim_way = '0;
        bus.cacop_en = 1'b0; bus.cacop_code = '0; bus.i_arready = 1'b0; bus.i_rvalid = 1'b0;
        bus.i_rlast = 1'b0;
    endtask

    task automatic apply(input vec_t t);
        int e;
        @(negedge clk);
        bus.rvalid = t.rvalid; bus.addr = t.addr; bus.uncache = t.unc; bus.hit = t.hit;
        bus.victim_way = t.vic; bus.cacop_en = t.cop; bus.cacop_code = t.code;
        bus.i_arready = t.arr; bus.i_rvalid = t.rvd; bus.i_rlast = t.rl;
        if (t.arr && t.ctl[5]) exp_beat = 0;
        if (t.ctl[3]) begin
            sb_q.push_back(exp_beat);
            exp_beat = (exp_beat + 1) % 4;
        end
        #1;
        chk({t.name, ".ctl"}, 32'(ctl_now), 32'(t.ctl));
        chk({t.name, ".mem_we"}, 32'(bus.mem_we), 32'(t.mw));
        chk({t.name, ".tagv_we"}, 32'(bus.tagv_we), 32'(t.tw));
        chk({t.name, ".araddr"}, bus.i_araddr, t.ara);
        chk({t.name, ".arlen"}, 32'(bus.i_arlen), 32'(t.arl));
        if (bus.beat_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s.beat: got unexpected beat idx %0d expected none", t.name, bus.beat_idx);
            end else begin
                e = sb_q.pop_front();
                chk({t.name, ".beat_idx"}, 32'(bus.beat_idx), 32'(e));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        drive_idle();
        // In-reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst.ctl", 32'(ctl_now), 32'(O_IDLE));
        chk("rst.fill_way", 32'(bus.fill_way), 32'd0);
        chk("rst.beat_idx", 32'(bus.beat_idx), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        vecs.push_back(v("idle",        0, 32'h1C008010, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("hit_req",     1, 32'h1C008010, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("hit_w2",      0, 32'h1C008010, 0, 4'b0100, 0, 0, 0, 0, 0, 0, O_HIT,    0, 0, 0, 0));
        vecs.push_back(v("b2b_req",     1, 32'h1C008020, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("b2b_hit0",    1, 32'h1C008020, 0, 4'b0001, 0, 0, 0, 0, 0, 0, O_HIT,    0, 0, 0, 0));
        vecs.push_back(v("b2b_hit1",    0, 32'h1C008024, 0, 4'b0010, 0, 0, 0, 0, 0, 0, O_HIT,    0, 0, 0, 0));
        vecs.push_back(v("miss_req",    1, 32'h1C008014, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("miss_lk",     0, 32'h1C008014, 0, 4'b0000, 3, 0, 0, 0, 0, 0, O_NONE,   0, 0, 0, 0));
        vecs.push_back(v("miss_a0",     0, 32'h1C008014, 0, 4'b0000, 1, 0, 0, 0, 0, 0, O_ARV,    0, 0, 32'h1C008010, 3));
        vecs.push_back(v("miss_a1",     0, 32'h1C008014, 0, 4'b0000, 1, 0, 0, 0, 0, 0, O_ARV,    0, 0, 32'h1C008010, 3));
        vecs.push_back(v("miss_a2",     0, 32'h1C008014, 0, 4'b0000, 1, 0, 0, 1, 0, 0, O_ARV,    0, 0, 32'h1C008010, 3));
        vecs.push_back(v("beat0",       0, 32'h1C008014, 0, 4'b0000, 0, 0, 0, 0, 1, 0, O_BEAT,   0, 0, 0, 0));
        vecs.push_back(v("gap",         0, 32'h1C008014, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_WAIT,   0, 0, 0, 0));
        vecs.push_back(v("beat1",       0, 32'h1C008014, 0, 4'b0000, 0, 0, 0, 0, 1, 0, O_BEAT,   0, 0, 0, 0));
        vecs.push_back(v("beat2",       0, 32'h1C008014, 0, 4'b0000, 0, 0, 0, 0, 1, 0, O_BEAT,   0, 0, 0, 0));
        vecs.push_back(v("beat3",       0, 32'h1C008014, 0, 4'b0000, 0, 0, 0, 0, 1, 1, O_BEAT,   0, 0, 0, 0));
        vecs.push_back(v("refill",      0, 32'h1C008014, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_REFILL, 4'b1000, 4'b1000, 0, 0));
        vecs.push_back(v("post_idle",   0, 32'h1C008014, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("unc_req",     1, 32'h1FE001E6, 1, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("unc_lk",      0, 32'h1FE001E6, 1, 4'b0100, 2, 0, 0, 0, 0, 0, O_NONE,   0, 0, 0, 0));
        vecs.push_back(v("unc_ar",      0, 32'h1FE001E6, 1, 4'b0000, 0, 0, 0, 1, 0, 0, O_ARV,    0, 0, 32'h1FE001E4, 0));
        vecs.push_back(v("unc_beat",    0, 32'h1FE001E6, 1, 4'b0000, 0, 0, 0, 0, 1, 1, O_LAST_U, 0, 0, 0, 0));
        vecs.push_back(v("unc_idle",    0, 32'h00000000, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("cop2_req",    0, 32'h1C008010, 0, 4'b0000, 0, 1, 2, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("cop2",        0, 32'h1C008010, 0, 4'b0100, 0, 0, 2, 0, 0, 0, O_COP,    0, 4'b0100, 0, 0));
        vecs.push_back(v("cop2m_req",   0, 32'h1C008010, 0, 4'b0000, 0, 1, 2, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("cop2m",       0, 32'h1C008010, 0, 4'b0000, 0, 0, 2, 0, 0, 0, O_COP,    0, 0, 0, 0));
        vecs.push_back(v("cop0_req",    0, 32'h00000001, 0, 4'b0000, 0, 1, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("cop0",        0, 32'h00000001, 0, 4'b1000, 0, 0, 0, 0, 0, 0, O_COP,    0, 4'b0010, 0, 0));
        vecs.push_back(v("cop1_req",    0, 32'h00000003, 0, 4'b0000, 0, 1, 1, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("cop1",        0, 32'h00000003, 0, 4'b0001, 0, 0, 1, 0, 0, 0, O_COP,    0, 4'b1000, 0, 0));
        vecs.push_back(v("cop3_req",    0, 32'h00000002, 0, 4'b0000, 0, 1, 3, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("cop3",        0, 32'h00000002, 0, 4'b1111, 0, 0, 3, 0, 0, 0, O_COP,    0, 0, 0, 0));
        vecs.push_back(v("both_req",    1, 32'h1C008050, 0, 4'b0000, 0, 1, 3, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("both_cop",    1, 32'h1C008050, 0, 4'b0001, 0, 0, 3, 0, 0, 0, O_COP,    0, 0, 0, 0));
        vecs.push_back(v("both_idle",   1, 32'h1C008050, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("both_lk",     0, 32'h1C008050, 0, 4'b0001, 0, 0, 0, 0, 0, 0, O_HIT,    0, 0, 0, 0));
        vecs.push_back(v("lkcop_req",   1, 32'h1C008060, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));
        vecs.push_back(v("lkcop_lk",    1, 32'h1C008060, 0, 4'b0001, 0, 1, 2, 0, 0, 0, O_NONE,   0, 0, 0, 0));
        vecs.push_back(v("lkcop_op",    1, 32'h1C008060, 0, 4'b0001, 0, 0, 2, 0, 0, 0, O_COP,    0, 4'b0001, 0, 0));
        vecs.push_back(v("end_idle",    0, 32'h00000000, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE,   0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset asserted in the middle of beat 2 of a refill burst
        apply(v("r_req", 1, 32'h1C008034, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0, 0));
        apply(v("r_lk",  0, 32'h1C008034, 0, 4'b0000, 2, 0, 0, 0, 0, 0, O_NONE, 0, 0, 0, 0));
        apply(v("r_ar",  0, 32'h1C008034, 0, 4'b0000, 0, 0, 0, 1, 0, 0, O_ARV,  0, 0, 32'h1C008030, 3));
        apply(v("r_b0",  0, 32'h1C008034, 0, 4'b0000, 0, 0, 0, 0, 1, 0, O_BEAT, 0, 0, 0, 0));
        apply(v("r_b1",  0, 32'h1C008034, 0, 4'b0000, 0, 0, 0, 0, 1, 0, O_BEAT, 0, 0, 0, 0));
        @(negedge clk);
        bus.i_rvalid = 1'b1;
        #1;
        chk("r_b2.beat_idx", 32'(bus.beat_idx), 32'd2);
        rstn = 1'b0;
        #1;
        chk("rst_mid.ctl", 32'(ctl_now), 32'(O_IDLE));
        chk("rst_mid.beat_idx", 32'(bus.beat_idx), 32'd0);
        chk("rst_mid.fill_way", 32'(bus.fill_way), 32'd0);
        chk("rst_mid.araddr", bus.i_araddr, 32'd0);
        drive_idle();
        @(negedge clk);
        rstn = 1'b1;

        apply(v("r2_req",  1, 32'h1C008044, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0, 0));
        apply(v("r2_lk",   0, 32'h1C008044, 0, 4'b0000, 1, 0, 0, 0, 0, 0, O_NONE, 0, 0, 0, 0));
        apply(v("r2_ar",   0, 32'h1C008044, 0, 4'b0000, 0, 0, 0, 1, 0, 0, O_ARV,  0, 0, 32'h1C008040, 3));
        apply(v("r2_b0",   0, 32'h1C008044, 0, 4'b0000, 0, 0, 0, 0, 1, 0, O_BEAT, 0, 0, 0, 0));
        apply(v("r2_b1",   0, 32'h1C008044, 0, 4'b0000, 0, 0, 0, 0, 1, 0, O_BEAT, 0, 0, 0, 0));
        apply(v("r2_b2",   0, 32'h1C008044, 0, 4'b0000, 0, 0, 0, 0, 1, 0, O_BEAT, 0, 0, 0, 0));
        apply(v("r2_b3",   0, 32'h1C008044, 0, 4'b0000, 0, 0, 0, 0, 1, 1, O_BEAT, 0, 0, 0, 0));
        apply(v("r2_fill", 0, 32'h1C008044, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_REFILL, 4'b0010, 4'b0010, 0, 0));
        chk("r2_fill.fill_way", 32'(bus.fill_way), 32'd1);
        apply(v("r2_idle", 0, 32'h00000000, 0, 4'b0000, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0, 0));

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
